// File: rtl/project_types.sv
// ---------------------------------------------------------------------------
// project_types: shared stall encodings, controller states and reset level.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package project_types;

  typedef logic reset_status_t;
  localparam reset_status_t RST_ENABLE = 1'b0;

  // Bit k stalls pipeline position k: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB
  typedef logic [5:0] stall_t;
  localparam stall_t STALL_NONE = 6'b000000;
  localparam stall_t STALL_ID   = 6'b000111;
  localparam stall_t STALL_EX   = 6'b001111;
  localparam stall_t STALL_MEM  = 6'b011111;
  localparam stall_t STALL_ALL  = 6'b111111;

  typedef enum logic [0:0] {
    CTRL_NORMAL = 1'b0,
    CTRL_FLUSH  = 1'b1
  } ctrl_state_t;

  function automatic stall_t stall_merge(input logic exc, input logic mem,
                                         input logic ex, input logic id);
    if (exc)      return STALL_ALL;
    else if (mem) return STALL_MEM;
    else if (ex)  return STALL_EX;
    else if (id)  return STALL_ID;
    else          return STALL_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_stall_counter.sv
// ---------------------------------------------------------------------------
// mc_stall_counter: EX multi-cycle op sequencer (load / decrement / freeze / abort).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mc_stall_counter #(
  parameter int MC_LEN_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [MC_LEN_W-1:0] len,
  input  logic                freeze,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                stall_ex
);
  import project_types::*;

  localparam logic [MC_LEN_W-1:0] CNT_ONE = MC_LEN_W'(1);

  logic [MC_LEN_W-1:0] cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                start_ok;

  always_comb begin
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done     = 1'b0;
    stall_ex = busy_q;
    start_ok = start && !busy_q && !abort && (len != '0);
    if (abort) begin
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (busy_q) begin
      if (!freeze) begin
        if (cnt_q == CNT_ONE) begin
          done   = 1'b1;
          busy_d = 1'b0;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
    end else if (start_ok) begin
      // The start cycle itself is the first of the len EX cycles.
      if (len == CNT_ONE) begin
        done = 1'b1;
      end else begin
        cnt_d    = len - CNT_ONE;
        busy_d   = 1'b1;
        stall_ex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl: stall/flush controller for the 5-stage pipeline.
// Optional STALL_WATCHDOG_EN adds a sticky consecutive-stall watchdog. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_ctrl #(
  parameter int MC_LEN_W   = 4,
  parameter int PC_W       = 32,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                stallreq_mem,
  input  logic                ex_mc_start,
  input  logic [MC_LEN_W-1:0] ex_mc_len,
  input  logic                exc_req,
  input  logic [PC_W-1:0]     exc_vector,
  output logic [5:0]          stall,
  output logic                flush,
  output logic [PC_W-1:0]     new_pc,
  output logic                ex_mc_busy,
  output logic                ex_mc_done,
  output logic                wdog_err
);
  import project_types::*;

  ctrl_state_t     state_q, state_d;
  logic            flush_q, flush_d;
  logic [PC_W-1:0] new_pc_q, new_pc_d;
  logic            exc_take;
  logic            mc_stall_ex;

  // Exceptions arriving during the flush cycle belong to squashed instructions.
  assign exc_take = exc_req && (state_q == CTRL_NORMAL);

  mc_stall_counter #(
    .MC_LEN_W (MC_LEN_W)
  ) u_mc (
    .clk      (clk),
    .rst      (rst),
    .start    (ex_mc_start),
    .len      (ex_mc_len),
    .freeze   (stallreq_mem),
    .abort    (exc_take),
    .busy     (ex_mc_busy),
    .done     (ex_mc_done),
    .stall_ex (mc_stall_ex)
  );

  always_comb begin
    state_d  = state_q;
    flush_d  = 1'b0;
    new_pc_d = new_pc_q;
    case (state_q)
      CTRL_NORMAL: begin
        if (exc_take) begin
          state_d  = CTRL_FLUSH;
          flush_d  = 1'b1;
          new_pc_d = exc_vector;
        end
      end
      CTRL_FLUSH: state_d = CTRL_NORMAL;
      default:    state_d = CTRL_NORMAL;
    endcase
  end

  always_comb begin
    stall = STALL_NONE;
    if (state_q == CTRL_NORMAL) begin
      stall = stall_merge(exc_take, stallreq_mem, mc_stall_ex, stallreq_id);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q  <= CTRL_NORMAL;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  assign flush  = flush_q;
  assign new_pc = new_pc_q;

`ifdef STALL_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_LIMIT);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            wdog_err_q, wdog_err_d;

  always_comb begin
    wd_d       = wd_q;
    wdog_err_d = wdog_err_q;
    if ((stall == STALL_NONE) || flush_q) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + WD_W'(1);
    end
    if (wd_d == WD_MAX) begin
      wdog_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wd_q       <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wd_q       <= wd_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  logic unused_wdog_limit;
  assign unused_wdog_limit = ^WDOG_LIMIT;
  assign wdog_err          = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl: directed vector table for pipeline_ctrl plus watchdog sequence.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_ctrl;
  import project_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_mem, ex_mc_start, exc_req;
  logic [3:0]  ex_mc_len;
  logic [31:0] exc_vector;
  logic [5:0]  stall;
  logic        flush, ex_mc_busy, ex_mc_done, wdog_err;
  logic [31:0] new_pc;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .MC_LEN_W   (4),
    .PC_W       (32),
    .WDOG_LIMIT (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_mem (stallreq_mem),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_len    (ex_mc_len),
    .exc_req      (exc_req),
    .exc_vector   (exc_vector),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .ex_mc_busy   (ex_mc_busy),
    .ex_mc_done   (ex_mc_done),
    .wdog_err     (wdog_err)
  );

  typedef struct {
    logic        rst, id, mem, st;
    logic [3:0]  len;
    logic        exc;
    logic [31:0] vec;
    logic        chk;
    logic [5:0]  stall;
    logic        flush, busy, done, npc_chk;
    logic [31:0] npc;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic id, input logic mem, input logic st,
                     input logic [3:0] len, input logic exc, input logic [31:0] vec,
                     input logic chk, input logic [5:0] s, input logic f, input logic b,
                     input logic d, input logic nc, input logic [31:0] npc);
    vec_t v;
    v = '{r, id, mem, st, len, exc, vec, chk, s, f, b, d, nc, npc};
    tv.push_back(v);
  endtask

  task automatic check(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    else passed++;
  endtask

  initial begin
    // rst id mem st len exc vec           chk stall      fl bz dn nc npc
    add(0, 1, 1, 1, 4'd5, 1, 32'hDEAD0000, 0, STALL_NONE, 0, 0, 0, 0, 32'h0);
    add(0, 1, 1, 1, 4'd5, 1, 32'hDEAD0000, 1, STALL_ALL,  0, 0, 0, 1, 32'h0);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_NONE, 0, 0, 0, 1, 32'h0);
    // load-use
    add(1, 1, 0, 0, 4'd0, 0, 32'h0,        1, STALL_ID,   0, 0, 0, 0, 32'h0);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_NONE, 0, 0, 0, 0, 32'h0);
    // mul len=4
    add(1, 0, 0, 1, 4'd4, 0, 32'h0,        1, STALL_EX,   0, 0, 0, 0, 32'h0);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_EX,   0, 1, 0, 0, 32'h0);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_EX,   0, 1, 0, 0, 32'h0);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_EX,   0, 1, 1, 0, 32'h0);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_NONE, 0, 0, 0, 0, 32'h0);
    // mul len=4 with a 2-cycle MEM wait
    add(1, 0, 0, 1, 4'd4, 0, 32'h0,        1, STALL_EX,   0, 0, 0, 0, 32'h0);
    add(1, 0, 1, 0, 4'd0, 0, 32'h0,        1, STALL_MEM,  0, 1, 0, 0, 32'h0);
    add(1, 0, 1, 0, 4'd0, 0, 32'h0,        1, STALL_MEM,  0, 1, 0, 0, 32'h0);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_EX,   0, 1, 0, 0, 32'h0);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_EX,   0, 1, 0, 0, 32'h0);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_EX,   0, 1, 1, 0, 32'h0);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_NONE, 0, 0, 0, 0, 32'h0);
    // len=1 and len=0
    add(1, 0, 0, 1, 4'd1, 0, 32'h0,        1, STALL_NONE, 0, 0, 1, 0, 32'h0);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_NONE, 0, 0, 0, 0, 32'h0);
    add(1, 0, 0, 1, 4'd0, 0, 32'h0,        1, STALL_NONE, 0, 0, 0, 0, 32'h0);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_NONE, 0, 0, 0, 0, 32'h0);
    // exception mid-mul
    add(1, 0, 0, 1, 4'd8, 0, 32'h0,        1, STALL_EX,   0, 0, 0, 0, 32'h0);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_EX,   0, 1, 0, 0, 32'h0);
    add(1, 0, 0, 0, 4'd0, 1, 32'hBFC00380, 1, STALL_ALL,  0, 1, 0, 0, 32'h0);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_NONE, 1, 0, 0, 1, 32'hBFC00380);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_NONE, 0, 0, 0, 0, 32'h0);
    // back-to-back exceptions
    add(1, 0, 0, 0, 4'd0, 1, 32'h11111111, 1, STALL_ALL,  0, 0, 0, 0, 32'h0);
    add(1, 0, 0, 0, 4'd0, 1, 32'h22222222, 1, STALL_NONE, 1, 0, 0, 1, 32'h11111111);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_NONE, 0, 0, 0, 0, 32'h0);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_NONE, 0, 0, 0, 0, 32'h0);
    // start while busy is ignored
    add(1, 0, 0, 1, 4'd3, 0, 32'h0,        1, STALL_EX,   0, 0, 0, 0, 32'h0);
    add(1, 0, 0, 1, 4'd9, 0, 32'h0,        1, STALL_EX,   0, 1, 0, 0, 32'h0);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_EX,   0, 1, 1, 0, 32'h0);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_NONE, 0, 0, 0, 0, 32'h0);
    // ID request under a busy op
    add(1, 1, 0, 1, 4'd2, 0, 32'h0,        1, STALL_EX,   0, 0, 0, 0, 32'h0);
    add(1, 1, 0, 0, 4'd0, 0, 32'h0,        1, STALL_EX,   0, 1, 1, 0, 32'h0);
    add(1, 1, 0, 0, 4'd0, 0, 32'h0,        1, STALL_ID,   0, 0, 0, 0, 32'h0);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_NONE, 0, 0, 0, 0, 32'h0);
    // exception beats MEM stall
    add(1, 0, 1, 0, 4'd0, 1, 32'h33333330, 1, STALL_ALL,  0, 0, 0, 0, 32'h0);
    add(1, 0, 1, 0, 4'd0, 0, 32'h0,        1, STALL_NONE, 1, 0, 0, 1, 32'h33333330);
    add(1, 0, 1, 0, 4'd0, 0, 32'h0,        1, STALL_MEM,  0, 0, 0, 0, 32'h0);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_NONE, 0, 0, 0, 0, 32'h0);
    // reset mid-op, then reset mid-flush
    add(1, 0, 0, 1, 4'd5, 0, 32'h0,        1, STALL_EX,   0, 0, 0, 0, 32'h0);
    add(0, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_EX,   0, 1, 0, 0, 32'h0);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_NONE, 0, 0, 0, 0, 32'h0);
    add(1, 0, 0, 0, 4'd0, 1, 32'h00000044, 1, STALL_ALL,  0, 0, 0, 0, 32'h0);
    add(0, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_NONE, 1, 0, 0, 1, 32'h00000044);
    add(1, 0, 0, 0, 4'd0, 0, 32'h0,        1, STALL_NONE, 0, 0, 0, 1, 32'h0);

    for (int i = 0; i < tv.size(); i++) begin
      rst          = tv[i].rst;
      stallreq_id  = tv[i].id;
      stallreq_mem = tv[i].mem;
      ex_mc_start  = tv[i].st;
      ex_mc_len    = tv[i].len;
      exc_req      = tv[i].exc;
      exc_vector   = tv[i].vec;
      @(negedge clk);
      if (tv[i].chk) begin
        check("stall", i, {26'b0, stall}, {26'b0, tv[i].stall});
        check("flush", i, {31'b0, flush}, {31'b0, tv[i].flush});
        check("ex_mc_busy", i, {31'b0, ex_mc_busy}, {31'b0, tv[i].busy});
        check("ex_mc_done", i, {31'b0, ex_mc_done}, {31'b0, tv[i].done});
        check("wdog_err", i, {31'b0, wdog_err}, 32'h0);
        if (tv[i].npc_chk) check("new_pc", i, new_pc, tv[i].npc);
      end
      @(posedge clk);
      #1;
    end

`ifdef STALL_WATCHDOG_EN
    rst = 1'b1; stallreq_id = 1'b0; ex_mc_start = 1'b0; exc_req = 1'b0;
    stallreq_mem = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check("wdog_rise", 100 + k, {31'b0, wdog_err}, {31'b0, (k >= 17)});
      @(posedge clk);
      #1;
    end
    stallreq_mem = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("wdog_sticky", 200 + k, {31'b0, wdog_err}, 32'h1);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("wdog_reset", 300, {31'b0, wdog_err}, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
